// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared HI/LO operation codes, controller states and opcode helpers
package mycpu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_DIV   = 3'd0,
    OP_DIVU  = 3'd1,
    OP_MULT  = 3'd2,
    OP_MULTU = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DIV_SEND = 3'd1,
    S_DIV_WAIT = 3'd2,
    S_MUL      = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  function automatic logic is_mt(input op_t op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  function automatic logic is_mul(input op_t op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_fsm.sv
// rtl/muldiv_fsm.sv - state register and sequencing for the HI/LO controller, incl. divider flush draining
module muldiv_fsm
  import mycpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   accept,
  input  op_t    op,
  input  logic   bypass,
  input  logic   flush,
  input  logic   div_tready,
  input  logic   div_dout_tvalid,
  output state_t state,
  output logic   div_tvalid
);

  // A flush seen while operands are still being offered cannot cancel the
  // handshake; remember it so the divider's eventual result gets drained.
  logic kill;

  // Single sequential FSM: state, sticky kill flag and the divider valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      kill       <= 1'b0;
      div_tvalid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          kill <= 1'b0;
          if (accept) begin
            if (is_mul(op)) begin
              state <= S_MUL;
            end else if (is_div(op) && !bypass) begin
              state      <= S_DIV_SEND;
              div_tvalid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          // Commit or flush, the product is only ever held for one cycle.
          state <= S_IDLE;
        end
        S_DIV_SEND: begin
          if (div_tready) begin
            div_tvalid <= 1'b0;
            kill       <= 1'b0;
            state      <= (kill || flush) ? S_DRAIN : S_DIV_WAIT;
          end else if (flush) begin
            kill <= 1'b1;
          end
        end
        S_DIV_WAIT: begin
          if (flush) begin
            state <= div_dout_tvalid ? S_IDLE : S_DRAIN;
          end else if (div_dout_tvalid) begin
            state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (div_dout_tvalid) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          kill       <= 1'b0;
          div_tvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide controller; define MULDIV_DIVZERO_BYPASS_EN to skip zero-divisor divides
module muldiv_ctrl
  import mycpu_pkg::*;
#(
  parameter int WD = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [OP_W-1:0] req_op,
  input  logic [WD-1:0]   src1,
  input  logic [WD-1:0]   src2,
  input  logic            flush,
  output logic            req_ready,
  output logic            busy,
  output logic            done,
  output logic [WD-1:0]   hi,
  output logic [WD-1:0]   lo,
  output logic            div_tvalid,
  input  logic            div_tready,
  output logic            div_signed,
  output logic [WD-1:0]   div_dividend,
  output logic [WD-1:0]   div_divisor,
  input  logic            div_dout_tvalid,
  input  logic [2*WD-1:0] div_dout_tdata
);

  state_t          state;
  op_t             req_code;
  op_t             op_q;
  logic [WD-1:0]   op_a;
  logic [WD-1:0]   op_b;
  logic            accept;
  logic            mt_accept;
  logic            div_bypass;
  logic            mul_commit;
  logic            div_commit;
  logic [2*WD-1:0] ext_a;
  logic [2*WD-1:0] ext_b;
  logic [2*WD-1:0] product;

  assign req_code  = op_t'(req_op);
  assign req_ready = (state == S_IDLE) & ~flush;
  assign accept    = req_valid & req_ready;
  assign mt_accept = accept & is_mt(req_code);
  assign busy      = (state != S_IDLE) | (accept & ~is_mt(req_code));

`ifdef MULDIV_DIVZERO_BYPASS_EN
  assign div_bypass = is_div(req_code) & (src2 == '0);
`else
  assign div_bypass = 1'b0;
`endif

  // Extending to full width first lets one truncated multiply serve both
  // signed and unsigned products.
  assign ext_a   = (op_q == OP_MULT) ? {{WD{op_a[WD-1]}}, op_a} : {{WD{1'b0}}, op_a};
  assign ext_b   = (op_q == OP_MULT) ? {{WD{op_b[WD-1]}}, op_b} : {{WD{1'b0}}, op_b};
  assign product = ext_a * ext_b;

  assign mul_commit = (state == S_MUL) & ~flush;
  assign div_commit = (state == S_DIV_WAIT) & div_dout_tvalid & ~flush;

  assign div_signed   = (op_q == OP_DIV);
  assign div_dividend = op_a;
  assign div_divisor  = op_b;

  muldiv_fsm u_fsm (
    .clk             (clk),
    .reset           (reset),
    .accept          (accept),
    .op              (req_code),
    .bypass          (div_bypass),
    .flush           (flush),
    .div_tready      (div_tready),
    .div_dout_tvalid (div_dout_tvalid),
    .state           (state),
    .div_tvalid      (div_tvalid)
  );

  // Latch operands and opcode on acceptance; they stay stable for the divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
      op_q <= OP_DIV;
    end else if (accept) begin
      op_a <= src1;
      op_b <= src2;
      op_q <= req_code;
    end
  end

  // Architectural HI/LO writes and the one-cycle done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      if (mt_accept && (req_code == OP_MTHI)) begin
        hi <= src1;
      end
      if (mt_accept && (req_code == OP_MTLO)) begin
        lo <= src1;
      end
      if (mul_commit) begin
        hi <= product[2*WD-1:WD];
        lo <= product[WD-1:0];
      end
      if (div_commit) begin
        lo <= div_dout_tdata[2*WD-1:WD];
        hi <= div_dout_tdata[WD-1:0];
      end
      done <= mt_accept | (accept & div_bypass) | mul_commit | div_commit;
    end
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter: WD, 32, operand/HI/LO width.
REQ-002 SHALL have port: clk  in  1  single clock, rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req_valid  in  1  EXE offers a HI/LO operation.
REQ-005 SHALL have port: req_op  in  3  operation code: DIV, DIVU, MULT, MULTU, MTHI, MTLO.
REQ-006 SHALL have port: src1 / src2  in  WD  rs / rt values.
REQ-007 SHALL have port: flush  in  1  exception or ERET cancel from MEM/WB.
REQ-008 SHALL have port: req_ready  out  1  request accepted this cycle.
REQ-009 SHALL have port: busy  out  1  EXE stall while an operation is in flight.
REQ-010 SHALL have port: done  out  1  one-cycle pulse on HI/LO commit.
REQ-011 SHALL have port: hi / lo  out  WD  architectural HI/LO.
REQ-012 SHALL have port: div_tvalid  out  1  operand valid to divider IP, dividend and divisor share it.
REQ-013 SHALL have port: div_tready  in  1  divider accepts operands.
REQ-014 SHALL have port: div_signed  out  1  selects the signed divider.
REQ-015 SHALL have port: div_dividend / div_divisor  out  WD  latched operands.
REQ-016 SHALL have port: div_dout_tvalid  in  1  divider result valid.
REQ-017 SHALL have port: div_dout_tdata  in  2*WD  quotient in [63:32], remainder in [31:0].

Function
REQ-018 SHALL implement the states IDLE, DIV_SEND, DIV_WAIT, MUL and DRAIN.
REQ-019 SHALL drive req_ready = (state==IDLE) & ~flush.
REQ-020 SHALL accept a request when req_valid & req_ready, latching src1, src2 and req_op.
REQ-021 SHALL, for MTHI/MTLO, write hi or lo with src1 at the acceptance edge, pulse done the next cycle and stay in IDLE.
REQ-022 SHALL, for MULT/MULTU, go from IDLE to MUL and compute the signed or unsigned 2*WD product of the latched operands.
REQ-023 SHALL, at the end of MUL, write hi = product[63:32] and lo = product[31:0], pulse done and return to IDLE (2 cycles after acceptance).
REQ-024 SHALL, for DIV/DIVU, go from IDLE to DIV_SEND with div_tvalid=1.
REQ-025 SHALL hold div_tvalid, div_dividend and div_divisor stable until div_tvalid & div_tready, then go to DIV_WAIT.
REQ-026 SHALL, in DIV_WAIT on div_dout_tvalid, write lo = quotient and hi = remainder, pulse done and return to IDLE.
REQ-027 SHALL drive busy = (state != IDLE) | (req_valid & req_ready & op is not MTHI/MTLO).
REQ-028 SHALL treat flush in MUL as: discard the product, leave hi/lo unchanged, go to IDLE, no done.
REQ-029 SHALL treat flush in DIV_SEND as: keep div_tvalid until handshake, then go to DRAIN.
REQ-030 SHALL treat flush in DIV_WAIT as: go to DRAIN.
REQ-031 SHALL, in DRAIN, wait for div_dout_tvalid, discard the result without a hi/lo write, then go to IDLE; busy stays 1.
REQ-032 SHALL give priority to a simultaneous flush and div_dout_tvalid in DIV_WAIT: the result is discarded and the block goes directly to IDLE.
REQ-033 SHALL NOT accept a request when req_valid and flush coincide in IDLE; hi/lo are untouched.
REQ-034 SHALL ignore div_dout_tvalid in IDLE/MUL.

Reset
REQ-035 SHALL on reset assertion immediately force state=IDLE, hi=0, lo=0, done=0, div_tvalid=0, busy=0 and latched operands=0.
REQ-036 SHALL, after reset mid-division, ignore a late div_dout_tvalid (IDLE rule).

Configuration
REQ-037 SHALL provide MULDIV_DIVZERO_BYPASS_EN: when defined, DIV/DIVU with src2==0 never enters DIV_SEND; hi/lo are unchanged and done pulses 1 cycle after acceptance.
REQ-038 SHALL, when MULDIV_DIVZERO_BYPASS_EN is undefined, send a zero divisor to the divider like any other and commit whatever it returns.

Structure
REQ-039 SHALL place the req_op encodings and state encodings in the shared mycpu header/package.
REQ-040 SHALL use one sub-module, muldiv_fsm, holding the state register and next-state logic; the multiplier and hi/lo registers stay in muldiv_ctrl.

Verification
REQ-041 SHALL cover: MULT src1=0xFFFFFFFF, src2=2 -> 2 cycles later hi=0xFFFFFFFF, lo=0xFFFFFFFE, done=1.
REQ-042 SHALL cover: MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-043 SHALL cover: DIV src1=-7, src2=2 with div_tready delayed 3 cycles -> div_tvalid held 4 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF, busy=1 until done.
REQ-044 SHALL cover: DIVU 100/7 with flush in DIV_WAIT -> DRAIN, result 14/2 discarded, hi/lo keep prior values, busy falls after dout_tvalid.
REQ-045 SHALL cover: MTHI 0x12345678 then MTLO 0x9ABCDEF0 on back-to-back cycles -> hi/lo exact, busy never 1.
REQ-046 SHALL cover: reset asserted in DIV_SEND -> div_tvalid=0 asynchronously, later dout_tvalid ignored, hi=lo=0.
